// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S DAC transmitter.
// Holds FSM state encoding, sample type and slot-position helper.
package i2s_pkg;

   localparam int DEF_CLK_DIV   = 8;
   localparam int DEF_WORD_BITS = 24;
   localparam int DEF_SLOT_BITS = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LEFT  = 2'd1,
      RIGHT = 2'd2
   } i2s_state_t;

   typedef logic signed [DEF_WORD_BITS-1:0] sample_t;

   // Data bit index for frame bit k: one BCLK behind the slot
   // position, so slot position 0 carries the previous slot's tail.
   function automatic int data_idx(input int k, input int slot);
      int s;
      s = (k >= slot) ? k - slot : k;
      return (s == 0) ? slot - 1 : s - 1;
   endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// BCLK divider: toggles bclk every CLK_DIV ck while run=1.
// Ports: ck_i, rst_i, run_i (0 holds bclk low) -> bclk_o, fall_o.
module i2s_bclk_gen #(
   parameter int CLK_DIV = 8
) (
   input  logic ck_i,
   input  logic rst_i,
   input  logic run_i,
   output logic bclk_o,
   output logic fall_o
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DW-1:0] div_q, div_d;
   logic          bclk_q, bclk_d;
   logic          tc;

   assign tc = (div_q == DW'(CLK_DIV - 1));

   always_comb begin
      div_d  = div_q;
      bclk_d = bclk_q;
      if (!run_i) begin
         div_d  = '0;
         bclk_d = 1'b0;
      end else if (tc) begin
         div_d  = '0;
         bclk_d = ~bclk_q;
      end else begin
         div_d = div_q + 1'b1;
      end
   end

   always_ff @(posedge ck_i) begin
      if (rst_i) begin
         div_q  <= '0;
         bclk_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         bclk_q <= bclk_d;
      end
   end

   // Combinational so the top updates lrck/dacdat on the same
   // posedge that drives bclk low.
   assign fall_o = run_i & tc & bclk_q;
   assign bclk_o = bclk_q;

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S master transmitter: mono sample sent on both channels, Philips format.
// Ports: ck, rst, en, sample/sample_ready in; bclk, lrck, dacdat, busy, underrun, overrun out.
module i2s_dac_tx
   import i2s_pkg::*;
#(
   parameter int CLK_DIV   = DEF_CLK_DIV,
   parameter int WORD_BITS = DEF_WORD_BITS,
   parameter int SLOT_BITS = DEF_SLOT_BITS
) (
   input  logic                        ck,
   input  logic                        rst,
   input  logic                        en,
   input  logic signed [WORD_BITS-1:0] sample,
   input  logic                        sample_ready,
   output logic                        bclk,
   output logic                        lrck,
   output logic                        dacdat,
   output logic                        busy,
   output logic                        underrun,
   output logic                        overrun
);

   localparam int BW = $clog2(2 * SLOT_BITS);
   localparam int IW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

   i2s_state_t           state_q, state_d;
   logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [WORD_BITS-1:0] hold_q, hold_d;
   logic [WORD_BITS-1:0] last_q, last_d;
   logic [WORD_BITS-1:0] shreg_q, shreg_d;
   logic                 hold_vld_q, hold_vld_d;
   logic                 lrck_q, lrck_d;
   logic                 dat_q, dat_d;
   logic                 unr_q, unr_d;
   logic                 ovr_q, ovr_d;
   logic                 run, load, fall;
   logic                 slot_end, frame_end;
   int                   d;

   i2s_bclk_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_bclk (
      .ck_i  (ck),
      .rst_i (rst),
      .run_i (run),
      .bclk_o(bclk),
      .fall_o(fall)
   );

   assign slot_end  = fall && (bit_cnt_q == BW'(SLOT_BITS - 1));
   assign frame_end = fall && (bit_cnt_q == BW'(2 * SLOT_BITS - 1));

   // State register
   always_ff @(posedge ck) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (en) state_d = LEFT;
         LEFT:    if (slot_end) state_d = RIGHT;
         RIGHT:   if (frame_end) state_d = en ? LEFT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy = (state_q != IDLE);
      run  = busy;
      load = (state_d == LEFT) && (state_q != LEFT);
   end

   // Bit counter and serial outputs, updated only on BCLK falls
   always_comb begin
      bit_cnt_d = bit_cnt_q;
      lrck_d    = lrck_q;
      dat_d     = dat_q;
      d         = 0;
      if (state_q == IDLE) begin
         bit_cnt_d = '0;
         lrck_d    = 1'b1;
         dat_d     = 1'b0;
      end else if (fall) begin
         bit_cnt_d = frame_end ? '0 : bit_cnt_q + 1'b1;
         lrck_d    = (int'(bit_cnt_q) >= SLOT_BITS);
         d         = data_idx(int'(bit_cnt_q), SLOT_BITS);
         if (d < WORD_BITS) dat_d = shreg_q[IW'(WORD_BITS - 1 - d)];
         else               dat_d = 1'b0;
      end
   end

   // Holding register, frame load and flags.
   // A load and a capture in the same cycle: load sees the old hold.
   always_comb begin
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      last_d     = last_q;
      shreg_d    = shreg_q;
      unr_d      = 1'b0;
      ovr_d      = 1'b0;
      if (load) begin
         if (hold_vld_q) begin
            shreg_d    = hold_q;
            last_d     = hold_q;
            hold_vld_d = 1'b0;
         end else begin
            shreg_d = last_q;
            unr_d   = 1'b1;
         end
      end
      if (sample_ready) begin
         hold_d     = sample;
         hold_vld_d = 1'b1;
         ovr_d      = hold_vld_q & ~load;
      end
   end

   always_ff @(posedge ck) begin
      if (rst) begin
         bit_cnt_q  <= '0;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         last_q     <= '0;
         shreg_q    <= '0;
         lrck_q     <= 1'b1;
         dat_q      <= 1'b0;
         unr_q      <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         bit_cnt_q  <= bit_cnt_d;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         last_q     <= last_d;
         shreg_q    <= shreg_d;
         lrck_q     <= lrck_d;
         dat_q      <= dat_d;
         unr_q      <= unr_d;
         ovr_q      <= ovr_d;
      end
   end

   assign lrck     = lrck_q;
   assign dacdat   = dat_q;
   assign underrun = unr_q;
   assign overrun  = ovr_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: decodes the I2S stream and scoreboards frames.
// CLK_DIV=2 at a 1 MHz ck.
`timescale 1ns/1ps
module tb_i2s_dac_tx;

   typedef struct {
      logic        lr;
      logic [23:0] w;
   } rx_t;

   logic        ck = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [23:0] sample = '0;
   logic        sample_ready = 1'b0;
   logic        bclk, lrck, dacdat, busy, underrun, overrun;

   int cmp = 0;
   int errs = 0;

   rx_t         rxq[$];
   logic [23:0] expq[$];

   int pos = 100;
   logic lr_prev = 1'b1;
   logic bclk_prev = 1'b0;
   logic [23:0] acc = '0;
   int cyc = 0;
   logic have_rise = 1'b0;
   int per = 0;
   int slot_len = 0;
   int pad_err = 0;
   int un_cnt = 0;
   int ov_cnt = 0;

   i2s_dac_tx #(
      .CLK_DIV  (2),
      .WORD_BITS(24),
      .SLOT_BITS(32)
   ) dut (
      .ck          (ck),
      .rst         (rst),
      .en          (en),
      .sample      (sample),
      .sample_ready(sample_ready),
      .bclk        (bclk),
      .lrck        (lrck),
      .dacdat      (dacdat),
      .busy        (busy),
      .underrun    (underrun),
      .overrun     (overrun)
   );

   always #500 ck = ~ck;

   // I2S receiver: samples on BCLK rising, seen at negedge ck
   always @(negedge ck) begin
      if (rst || !busy) begin
         pos = 100;
         lr_prev = 1'b1;
         acc = '0;
         have_rise = 1'b0;
         cyc = 0;
      end else begin
         cyc++;
         if (bclk === 1'b1 && bclk_prev === 1'b0) begin
            if (have_rise) per = cyc;
            have_rise = 1'b1;
            cyc = 0;
            if (lrck !== lr_prev) begin
               if (pos <= 40) slot_len = pos + 1;
               pos = 0;
               acc = '0;
            end else begin
               pos++;
            end
            lr_prev = lrck;
            if (pos >= 1 && pos <= 24) acc = {acc[22:0], dacdat};
            else if (pos <= 31 && dacdat !== 1'b0) pad_err++;
            if (pos == 24) rxq.push_back('{lr: lrck, w: acc});
         end
      end
      bclk_prev = bclk;
   end

   always @(negedge ck) begin
      if (underrun === 1'b1) un_cnt++;
      if (overrun === 1'b1) ov_cnt++;
   end

   task automatic strobe(input logic [23:0] v);
      @(negedge ck);
      sample = v;
      sample_ready = 1'b1;
      @(negedge ck);
      sample_ready = 1'b0;
   endtask

   // Wait for lrck to leave v and return to v
   task automatic wait_edge(input logic v);
      int n;
      n = 0;
      while (lrck === v && n < 2000) begin
         @(negedge ck);
         n++;
      end
      while (lrck !== v && n < 2000) begin
         @(negedge ck);
         n++;
      end
      if (n >= 2000) begin
         cmp++;
         errs++;
         $display("FAIL wait_lrck timeout: lrck=%b required=%b", lrck, v);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge ck);
      while (busy !== 1'b0 && n < 2000) begin
         @(negedge ck);
         n++;
      end
      if (n >= 2000) begin
         cmp++;
         errs++;
         $display("FAIL wait_idle timeout: busy=%b required=0", busy);
      end
   endtask

   task automatic pop_frame(output logic got, output rx_t l,
                            output rx_t r, output logic [23:0] e);
      got = 1'b0;
      l = '{lr: 1'b0, w: '0};
      r = '{lr: 1'b0, w: '0};
      e = '0;
      if (rxq.size() >= 2 && expq.size() >= 1) begin
         l = rxq.pop_front();
         r = rxq.pop_front();
         e = expq.pop_front();
         got = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      en = 1'b0;
      repeat (2) @(negedge ck);
      cmp++; if (bclk !== 1'b0) begin errs++; $display("FAIL rst_bclk got=%b exp=0", bclk); end
      cmp++; if (lrck !== 1'b1) begin errs++; $display("FAIL rst_lrck got=%b exp=1", lrck); end
      cmp++; if (dacdat !== 1'b0) begin errs++; $display("FAIL rst_dacdat got=%b exp=0", dacdat); end
      cmp++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got=%b exp=0", busy); end
      cmp++; if (underrun !== 1'b0) begin errs++; $display("FAIL rst_underrun got=%b exp=0", underrun); end
      cmp++; if (overrun !== 1'b0) begin errs++; $display("FAIL rst_overrun got=%b exp=0", overrun); end
      rst = 1'b0;
      repeat (6) @(negedge ck);
      cmp++; if (busy !== 1'b0 || bclk !== 1'b0) begin
         errs++; $display("FAIL idle_hold busy=%b bclk=%b exp=0/0", busy, bclk);
      end
   endtask

   task automatic test_single();
      int u0;
      logic got;
      rx_t l, r;
      logic [23:0] e;
      u0 = un_cnt;
      strobe(24'h800001);
      expq.push_back(24'h800001);
      @(negedge ck);
      en = 1'b1;
      @(negedge ck);
      en = 1'b0;
      wait_idle();
      pop_frame(got, l, r, e);
      cmp++; if (!got || l.lr !== 1'b0 || l.w !== e) begin
         errs++; $display("FAIL single_left got=%b lr=%b w=%h exp=%h", got, l.lr, l.w, e);
      end
      cmp++; if (!got || r.lr !== 1'b1 || r.w !== e) begin
         errs++; $display("FAIL single_right got=%b lr=%b w=%h exp=%h", got, r.lr, r.w, e);
      end
      cmp++; if (slot_len !== 32) begin errs++; $display("FAIL slot_len got=%0d exp=32", slot_len); end
      cmp++; if (per !== 4) begin errs++; $display("FAIL bclk_period got=%0d exp=4", per); end
      cmp++; if (un_cnt - u0 !== 0) begin errs++; $display("FAIL single_underrun got=%0d exp=0", un_cnt - u0); end
      cmp++; if (bclk !== 1'b0 || lrck !== 1'b1 || dacdat !== 1'b0) begin
         errs++; $display("FAIL single_idle bclk=%b lrck=%b dat=%b exp=0/1/0", bclk, lrck, dacdat);
      end
   endtask

   task automatic test_stream();
      int u0, o0;
      logic got;
      rx_t l, r;
      logic [23:0] e;
      logic [23:0] vals [4];
      vals[0] = 24'h123456;
      vals[1] = 24'hEDCBAA;
      vals[2] = 24'h123456;
      vals[3] = 24'hEDCBAA;
      u0 = un_cnt;
      o0 = ov_cnt;
      strobe(vals[0]);
      expq.push_back(vals[0]);
      @(negedge ck);
      en = 1'b1;
      for (int i = 1; i < 4; i++) begin
         wait_edge(1'b1);
         strobe(vals[i]);
         expq.push_back(vals[i]);
      end
      wait_edge(1'b0);
      en = 1'b0;
      wait_idle();
      for (int i = 0; i < 4; i++) begin
         pop_frame(got, l, r, e);
         cmp++; if (!got || l.lr !== 1'b0 || l.w !== e || r.lr !== 1'b1 || r.w !== e) begin
            errs++; $display("FAIL stream_f%0d got=%b L=%h R=%h exp=%h", i, got, l.w, r.w, e);
         end
      end
      cmp++; if (un_cnt - u0 !== 0 || ov_cnt - o0 !== 0) begin
         errs++; $display("FAIL stream_flags un=%0d ov=%0d exp=0/0", un_cnt - u0, ov_cnt - o0);
      end
      cmp++; if (rxq.size() !== 0) begin errs++; $display("FAIL stream_extra got=%0d exp=0", rxq.size()); end
   endtask

   task automatic test_underrun();
      int u0, o0;
      logic got;
      rx_t l, r;
      logic [23:0] e;
      u0 = un_cnt;
      o0 = ov_cnt;
      strobe(24'h00F00F);
      repeat (3) expq.push_back(24'h00F00F);
      @(negedge ck);
      en = 1'b1;
      wait_edge(1'b1);
      wait_edge(1'b1);
      wait_edge(1'b0);
      en = 1'b0;
      wait_idle();
      for (int i = 0; i < 3; i++) begin
         pop_frame(got, l, r, e);
         cmp++; if (!got || l.w !== e || r.w !== e) begin
            errs++; $display("FAIL underrun_f%0d got=%b L=%h R=%h exp=%h", i, got, l.w, r.w, e);
         end
      end
      cmp++; if (un_cnt - u0 !== 2) begin errs++; $display("FAIL underrun_cnt got=%0d exp=2", un_cnt - u0); end
      cmp++; if (ov_cnt - o0 !== 0) begin errs++; $display("FAIL underrun_ov got=%0d exp=0", ov_cnt - o0); end
   endtask

   task automatic test_overrun();
      int u0, o0;
      logic got;
      rx_t l, r;
      logic [23:0] e;
      u0 = un_cnt;
      o0 = ov_cnt;
      expq.push_back(24'h00F00F);
      @(negedge ck);
      en = 1'b1;
      wait_edge(1'b1);
      strobe(24'h000011);
      repeat (3) @(negedge ck);
      strobe(24'h000022);
      expq.push_back(24'h000022);
      wait_edge(1'b0);
      en = 1'b0;
      wait_idle();
      for (int i = 0; i < 2; i++) begin
         pop_frame(got, l, r, e);
         cmp++; if (!got || l.w !== e || r.w !== e) begin
            errs++; $display("FAIL overrun_f%0d got=%b L=%h R=%h exp=%h", i, got, l.w, r.w, e);
         end
      end
      cmp++; if (ov_cnt - o0 !== 1) begin errs++; $display("FAIL overrun_cnt got=%0d exp=1", ov_cnt - o0); end
      cmp++; if (un_cnt - u0 !== 1) begin errs++; $display("FAIL overrun_un got=%0d exp=1", un_cnt - u0); end
   endtask

   task automatic test_coincident();
      int u0, o0;
      logic got;
      rx_t l, r;
      logic [23:0] e;
      u0 = un_cnt;
      o0 = ov_cnt;
      strobe(24'h7FFFFF);
      expq.push_back(24'h7FFFFF);
      @(negedge ck);
      en = 1'b1;
      sample = 24'hABCDEF;
      sample_ready = 1'b1;
      expq.push_back(24'hABCDEF);
      @(negedge ck);
      sample_ready = 1'b0;
      wait_edge(1'b1);
      wait_edge(1'b0);
      en = 1'b0;
      wait_idle();
      for (int i = 0; i < 2; i++) begin
         pop_frame(got, l, r, e);
         cmp++; if (!got || l.w !== e || r.w !== e) begin
            errs++; $display("FAIL coinc_f%0d got=%b L=%h R=%h exp=%h", i, got, l.w, r.w, e);
         end
      end
      cmp++; if (un_cnt - u0 !== 0 || ov_cnt - o0 !== 0) begin
         errs++; $display("FAIL coinc_flags un=%0d ov=%0d exp=0/0", un_cnt - u0, ov_cnt - o0);
      end
      repeat (4) @(negedge ck);
      cmp++; if (busy !== 1'b0 || bclk !== 1'b0) begin
         errs++; $display("FAIL stop_idle busy=%b bclk=%b exp=0/0", busy, bclk);
      end
   endtask

   task automatic test_reset_mid();
      int u0;
      logic got;
      rx_t l, r;
      logic [23:0] e;
      @(negedge ck);
      en = 1'b1;
      wait_edge(1'b0);
      repeat (40) @(negedge ck);
      rst = 1'b1;
      en = 1'b0;
      @(negedge ck);
      cmp++; if (bclk !== 1'b0 || lrck !== 1'b1 || dacdat !== 1'b0) begin
         errs++; $display("FAIL midrst_out bclk=%b lrck=%b dat=%b exp=0/1/0", bclk, lrck, dacdat);
      end
      cmp++; if (busy !== 1'b0 || underrun !== 1'b0 || overrun !== 1'b0) begin
         errs++; $display("FAIL midrst_flags busy=%b un=%b ov=%b exp=0/0/0", busy, underrun, overrun);
      end
      @(negedge ck);
      rst = 1'b0;
      rxq.delete();
      repeat (5) @(negedge ck);
      cmp++; if (busy !== 1'b0) begin errs++; $display("FAIL midrst_idle busy=%b exp=0", busy); end
      u0 = un_cnt;
      expq.push_back(24'h000000);
      en = 1'b1;
      wait_edge(1'b0);
      en = 1'b0;
      wait_idle();
      pop_frame(got, l, r, e);
      cmp++; if (!got || l.w !== e || r.w !== e) begin
         errs++; $display("FAIL midrst_last got=%b L=%h R=%h exp=%h", got, l.w, r.w, e);
      end
      cmp++; if (un_cnt - u0 !== 1) begin errs++; $display("FAIL midrst_un got=%0d exp=1", un_cnt - u0); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_underrun();
      test_overrun();
      test_coincident();
      test_reset_mid();
      cmp++; if (pad_err !== 0) begin errs++; $display("FAIL padding got=%0d exp=0", pad_err); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
      $finish;
   end

endmodule
